common_lane_serializer: RTL and testbench
=========================================

# common_lane_serializer

Pipeline stage that accepts one wide word of up to LANE_COUNT lanes per handshake and emits its valid lanes one per cycle, lowest index first, with valid/ready flow control on both sides. It sits directly downstream of common_bypass_buffer, for example splitting a fetch packet into per-instruction beats for decode. The upstream port is driven by that buffer's next_o_* outputs. Input is refused while lanes of the previous word are still pending, except on the cycle its last lane is consumed.

## Interface
- LANE_WIDTH, 32, bits per lane.
- LANE_COUNT, 4, lanes per input word; must be at least 1.
- COUNT_WIDTH, 3, width of the count and index fields; must hold LANE_COUNT.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous drop of the held word.
- prev_i_data  input  LANE_WIDTH*LANE_COUNT  lane k occupies bits [k*LANE_WIDTH +: LANE_WIDTH].
- prev_i_count  input  COUNT_WIDTH  number of valid lanes, starting at lane 0.
- prev_i_valid  input  1  upstream word valid.
- prev_o_ready  output  1  stage can take a word this cycle.
- next_o_data  output  LANE_WIDTH  current lane.
- next_o_index  output  COUNT_WIDTH  index of the current lane within its word.
- next_o_last  output  1  current lane is the final valid lane of its word.
- next_o_valid  output  1  lane valid.
- next_i_ready  input  1  downstream accepts the lane.

## Operation
- State is busy (1 bit), held word, held count (clamped) and lane index.
- Accept: prev_i_valid & prev_o_ready.
  - On accept, the word and clamp(prev_i_count) are captured and index is set to 0.
  - busy is set if the clamped count is nonzero.
- clamp(c) = LANE_COUNT when c > LANE_COUNT, otherwise c.
- Count-0 words are accepted and dropped. No lane is emitted and busy stays 0.
- prev_o_ready = reset & ~flush & (~busy | (next_i_ready & next_o_last)).
  - The last-lane term gives zero-bubble back-to-back words.
  - This is a combinational path from next_i_ready to prev_o_ready. It is legal because upstream ready does not depend on its own downstream ready.
- next_o_valid = busy & ~flush.
- next_o_data is the held lane[index]. next_o_index = index. next_o_last = (index == held count - 1).
- Lane handshake (next_o_valid & next_i_ready):
  - If not last, index increments.
  - If last and no accept in the same cycle, busy clears.
  - If last and an accept occurs in the same cycle, the new word loads as above.
- Without a lane handshake, the outputs hold stable: data, index and last do not change while valid & ~ready.
- flush has highest priority:
  - busy clears and index returns to 0.
  - No accept and no lane handshake occur that cycle.
  - The data registers may keep stale contents.

## Timing
- Reset: busy=0, index=0, held count=0, held data=0.
  - Outputs during and after reset: next_o_valid=0, next_o_last=0, next_o_index=0, next_o_data=0.
  - prev_o_ready=0 while reset is low and 1 after release.
- Latency: a word accepted at edge T shows lane 0 in cycle T+1. There is no combinational data path from prev to next.
- Throughput: a word of n lanes with next_i_ready held high occupies exactly n cycles. The next word's lane 0 appears in the cycle immediately after the last lane.
- Reset asserted mid-word: all pending lanes are discarded immediately (asynchronous), with no partial output after release.
- Index never exceeds LANE_COUNT-1, so no wrap-around is possible.

## Test plan
- Reset and idle: hold reset low with prev_i_valid=1 -> prev_o_ready=0 and next_o_valid=0. After release with an idle input -> prev_o_ready=1 and next_o_valid=0.
- Single full word: LANE_COUNT=4, data lanes 0xA0..0xA3, count=4, next_i_ready=1.
  - Lanes 0xA0, 0xA1, 0xA2, 0xA3 appear in cycles T+1..T+4 with index 0..3.
  - next_o_last is 1 only at T+4. prev_o_ready is 0 in T+1..T+3 and 1 in T+4.
- Back-to-back words with counts 2 then 3, upstream valid continuously -> 5 consecutive valid cycles, no bubble, last pulses on the 2nd and 5th lanes.
- Backpressure: count=3, with next_i_ready toggling 1,0,0,1,1 -> each lane is held stable across the stall cycles and all 3 lanes are delivered in order with no loss or duplicate.
- Edge counts:
  - count=0 -> accepted, no next_o_valid, prev_o_ready stays 1.
  - count=7 -> clamped and emitted as 4 lanes.
  - count=1 -> a single lane with last=1.
- Flush and reset mid-word:
  - count=4, flush after lane 1 -> next_o_valid=0 in the flush cycle and stays 0 until the next accept.
  - Same scenario with reset asserted instead of flush -> outputs go to reset values asynchronously.

Source files
------------

// File: rtl/common_lane_serializer.sv
// ============================================================================
// common_lane_serializer
//
// Accepts one wide word of up to LANE_COUNT lanes per upstream handshake and
// emits its valid lanes one per cycle, lowest index first, with valid/ready
// flow control on both sides. A new word can be taken on the same cycle the
// last lane of the current word is consumed, so back-to-back words stream
// without a bubble.
//
// Parameters:
//   LANE_WIDTH   bits per lane
//   LANE_COUNT   lanes per input word (at least 1)
//   COUNT_WIDTH  width of the count and index fields (must hold LANE_COUNT)
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous active-low reset
//   flush         synchronous drop of the held word
//   prev_i_data   input word, lane k at [k*LANE_WIDTH +: LANE_WIDTH]
//   prev_i_count  number of valid lanes, starting at lane 0
//   prev_i_valid  upstream word valid
//   prev_o_ready  stage can take a word this cycle
//   next_o_data   current lane
//   next_o_index  index of the current lane within its word
//   next_o_last   current lane is the final valid lane of its word
//   next_o_valid  lane valid
//   next_i_ready  downstream accepts the lane
// ============================================================================
module common_lane_serializer #(
    parameter int LANE_WIDTH  = 32,
    parameter int LANE_COUNT  = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [LANE_WIDTH*LANE_COUNT-1:0] prev_i_data,
    input  logic [COUNT_WIDTH-1:0]           prev_i_count,
    input  logic                             prev_i_valid,
    output logic                             prev_o_ready,
    output logic [LANE_WIDTH-1:0]            next_o_data,
    output logic [COUNT_WIDTH-1:0]           next_o_index,
    output logic                             next_o_last,
    output logic                             next_o_valid,
    input  logic                             next_i_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(LANE_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

    state_t                           state;
    logic [LANE_WIDTH*LANE_COUNT-1:0] held_data;
    logic [COUNT_WIDTH-1:0]           held_count;
    logic [COUNT_WIDTH-1:0]           lane_index;
    logic [COUNT_WIDTH-1:0]           clamped_count;
    logic                             busy;
    logic                             accept;
    logic                             lane_fire;

    // Oversized counts are clamped to the physical lane count so the index
    // can never walk past the last lane of the held word.
    always_comb begin
        clamped_count = prev_i_count;
        if (prev_i_count > MAX_COUNT) begin
            clamped_count = MAX_COUNT;
        end
    end

    assign busy         = (state == ST_BUSY);
    assign next_o_valid = busy & ~flush;
    assign next_o_index = lane_index;
    // With held_count == 0 the subtraction wraps to all ones, which the
    // index never reaches, so an empty or reset stage never reports last.
    assign next_o_last  = (lane_index == (held_count - ONE));

    // The next_i_ready & next_o_last term lets a new word load on the cycle
    // the final lane leaves; this is a combinational ready-to-ready path.
    assign prev_o_ready = reset & ~flush & (~busy | (next_i_ready & next_o_last));
    assign accept       = prev_i_valid & prev_o_ready;
    assign lane_fire    = next_o_valid & next_i_ready;

    // Select the current lane from the held word. Comparing against each
    // constant lane number avoids indexing with a wider-than-needed index.
    always_comb begin
        next_o_data = '0;
        for (int k = 0; k < LANE_COUNT; k++) begin
            if (lane_index == COUNT_WIDTH'(k)) begin
                next_o_data = held_data[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Main state register. Flush wins over everything and leaves the data
    // registers untouched; an accept only happens while idle or while the
    // last lane is leaving, so it simply overwrites the finished word.
    // Count-0 words are captured but leave the stage idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            held_data  <= '0;
            held_count <= '0;
            lane_index <= '0;
        end else if (flush) begin
            state      <= ST_IDLE;
            lane_index <= '0;
        end else if (accept) begin
            held_data  <= prev_i_data;
            held_count <= clamped_count;
            lane_index <= '0;
            state      <= (clamped_count != '0) ? ST_BUSY : ST_IDLE;
        end else if (lane_fire) begin
            if (next_o_last) begin
                state <= ST_IDLE;
            end else begin
                lane_index <= lane_index + ONE;
            end
        end
    end

endmodule

// File: tb/tb_common_lane_serializer.sv
// ============================================================================
// tb_common_lane_serializer
//
// Directed bench for common_lane_serializer. Every accepted word pushes its
// expected lanes into a scoreboard queue; every lane handshake pops and
// compares data, index and last. Directed checks cover ready/valid/last
// timing, backpressure stability, edge counts, flush and async reset.
// ============================================================================
module tb_common_lane_serializer;

    localparam int LW = 32;
    localparam int LC = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [LW-1:0] data;
        logic [CW-1:0] index;
        logic          last;
    } lane_t;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [LW*LC-1:0] prev_i_data;
    logic [CW-1:0]    prev_i_count;
    logic             prev_i_valid;
    logic             prev_o_ready;
    logic [LW-1:0]    next_o_data;
    logic [CW-1:0]    next_o_index;
    logic             next_o_last;
    logic             next_o_valid;
    logic             next_i_ready;

    lane_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    common_lane_serializer #(
        .LANE_WIDTH (LW),
        .LANE_COUNT (LC),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .prev_i_data (prev_i_data),
        .prev_i_count(prev_i_count),
        .prev_i_valid(prev_i_valid),
        .prev_o_ready(prev_o_ready),
        .next_o_data (next_o_data),
        .next_o_index(next_o_index),
        .next_o_last (next_o_last),
        .next_o_valid(next_o_valid),
        .next_i_ready(next_i_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds a word whose lane k holds base + k.
    function automatic logic [LW*LC-1:0] make_word(input logic [LW-1:0] base);
        logic [LW*LC-1:0] w;
        w = '0;
        for (int k = 0; k < LC; k++) begin
            w[k*LW +: LW] = base + LW'(k);
        end
        return w;
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives the upstream and downstream inputs for the coming cycle.
    task automatic apply_stimulus(input logic valid, input logic [LW*LC-1:0] data,
                                  input logic [CW-1:0] count, input logic nready);
        prev_i_valid = valid;
        prev_i_data  = data;
        prev_i_count = count;
        next_i_ready = nready;
    endtask

    // Lets the combinational outputs settle, then runs the scoreboard: a lane
    // handshake pops and compares, a word handshake pushes the expected lanes.
    task automatic observe();
        lane_t exp_lane;
        int    n;
        #1;
        if (next_o_valid && next_i_ready) begin
            if (sb_q.size() == 0) begin
                check_output("sb_unexpected_lane", 32'(next_o_valid), 32'd0);
            end else begin
                exp_lane = sb_q.pop_front();
                check_output("sb_data", next_o_data, exp_lane.data);
                check_output("sb_index", 32'(next_o_index), 32'(exp_lane.index));
                check_output("sb_last", 32'(next_o_last), 32'(exp_lane.last));
            end
        end
        if (prev_i_valid && prev_o_ready) begin
            n = (int'(prev_i_count) > LC) ? LC : int'(prev_i_count);
            for (int k = 0; k < n; k++) begin
                exp_lane.data  = prev_i_data[k*LW +: LW];
                exp_lane.index = CW'(k);
                exp_lane.last  = (k == n - 1);
                sb_q.push_back(exp_lane);
            end
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    // Observe one cycle, check valid/ready (and last when exp_last >= 0),
    // then move to the next cycle.
    task automatic cycle_check(input string tag, input int exp_valid,
                               input int exp_ready, input int exp_last);
        observe();
        check_output({tag, "_valid"}, 32'(next_o_valid), 32'(exp_valid));
        check_output({tag, "_ready"}, 32'(prev_o_ready), 32'(exp_ready));
        if (exp_last >= 0) begin
            check_output({tag, "_last"}, 32'(next_o_last), 32'(exp_last));
        end
        advance();
    endtask

    // Checks that every output sits at its reset value.
    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_valid"}, 32'(next_o_valid), 32'd0);
        check_output({tag, "_ready"}, 32'(prev_o_ready), 32'd0);
        check_output({tag, "_last"}, 32'(next_o_last), 32'd0);
        check_output({tag, "_index"}, 32'(next_o_index), 32'd0);
        check_output({tag, "_data"}, next_o_data, 32'd0);
    endtask

    // Directed sequence, one cycle per step.
    initial begin
        logic [LW*LC-1:0] word_a;
        logic [LW*LC-1:0] word_b;
        logic [LW*LC-1:0] word_c;
        logic [LW*LC-1:0] word_d;

        word_a = make_word(32'hA0);
        word_b = make_word(32'hB0);
        word_c = make_word(32'hC0);
        word_d = make_word(32'hD0);

        $display("[TB] start");
        reset = 1'b0;
        flush = 1'b0;
        apply_stimulus(1'b1, word_a, 3'd4, 1'b1);

        // Reset held low with a valid upstream word.
        observe();
        check_reset_outputs("reset_hold");
        advance();
        cycle_check("reset_hold2", 0, 0, 0);

        // Release with an idle input.
        reset = 1'b1;
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("idle", 0, 1, 0);

        // Single full word, lanes A0..A3.
        apply_stimulus(1'b1, word_a, 3'd4, 1'b1);
        cycle_check("full_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle_check("full_lane", 1, (i == 3) ? 1 : 0, (i == 3) ? 1 : 0);
        end
        cycle_check("full_after", 0, 1, -1);

        // Back-to-back words of 2 then 3 lanes, no bubble.
        apply_stimulus(1'b1, word_b, 3'd2, 1'b1);
        cycle_check("b2b_acc", 0, 1, -1);
        apply_stimulus(1'b1, word_c, 3'd3, 1'b1);
        cycle_check("b2b_b0", 1, 0, 0);
        cycle_check("b2b_b1", 1, 1, 1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("b2b_c0", 1, 0, 0);
        cycle_check("b2b_c1", 1, 0, 0);
        cycle_check("b2b_c2", 1, 1, 1);
        cycle_check("b2b_after", 0, 1, -1);

        // Backpressure: ready pattern 1,0,0,1,1 over a 3-lane word.
        apply_stimulus(1'b1, word_d, 3'd3, 1'b1);
        cycle_check("bp_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        observe();
        check_output("bp_c1_index", 32'(next_o_index), 32'd0);
        check_output("bp_c1_data", next_o_data, 32'hD0);
        advance();
        for (int i = 0; i < 3; i++) begin
            next_i_ready = (i == 2);
            observe();
            check_output("bp_stall_valid", 32'(next_o_valid), 32'd1);
            check_output("bp_stall_index", 32'(next_o_index), 32'd1);
            check_output("bp_stall_data", next_o_data, 32'hD1);
            check_output("bp_stall_last", 32'(next_o_last), 32'd0);
            check_output("bp_stall_ready", 32'(prev_o_ready), 32'd0);
            advance();
        end
        next_i_ready = 1'b1;
        observe();
        check_output("bp_c5_index", 32'(next_o_index), 32'd2);
        check_output("bp_c5_data", next_o_data, 32'hD2);
        check_output("bp_c5_last", 32'(next_o_last), 32'd1);
        advance();
        cycle_check("bp_after", 0, 1, -1);

        // Count 0: accepted and dropped.
        apply_stimulus(1'b1, word_a, 3'd0, 1'b1);
        cycle_check("cnt0_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("cnt0_after", 0, 1, -1);
        cycle_check("cnt0_after2", 0, 1, -1);

        // Count 7: clamped to 4 lanes.
        apply_stimulus(1'b1, word_b, 3'd7, 1'b1);
        cycle_check("cnt7_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle_check("cnt7_lane", 1, (i == 3) ? 1 : 0, (i == 3) ? 1 : 0);
        end
        cycle_check("cnt7_after", 0, 1, -1);

        // Count 1: single lane marked last.
        apply_stimulus(1'b1, word_c, 3'd1, 1'b1);
        cycle_check("cnt1_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("cnt1_lane", 1, 1, 1);
        cycle_check("cnt1_after", 0, 1, -1);

        // Flush after lane 1 of a 4-lane word.
        apply_stimulus(1'b1, word_d, 3'd4, 1'b1);
        cycle_check("fl_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("fl_lane0", 1, 0, 0);
        cycle_check("fl_lane1", 1, 0, 0);
        flush = 1'b1;
        apply_stimulus(1'b1, word_a, 3'd2, 1'b1);
        cycle_check("fl_flush", 0, 0, -1);
        sb_q.delete();
        flush = 1'b0;
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("fl_idle1", 0, 1, -1);
        cycle_check("fl_idle2", 0, 1, -1);
        apply_stimulus(1'b1, word_a, 3'd1, 1'b1);
        cycle_check("fl_rec_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("fl_rec_lane", 1, 1, 1);

        // Reset asserted mid-word, away from any clock edge.
        apply_stimulus(1'b1, word_b, 3'd4, 1'b1);
        cycle_check("rs_acc", 0, 1, -1);
        apply_stimulus(1'b0, '0, 3'd0, 1'b1);
        cycle_check("rs_lane0", 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rs_async");
        sb_q.delete();
        advance();
        observe();
        check_reset_outputs("rs_held");
        advance();
        reset = 1'b1;
        cycle_check("rs_idle1", 0, 1, 0);
        cycle_check("rs_idle2", 0, 1, 0);

        // Every expected lane must have been delivered.
        check_output("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
